brc_arbiter: RTL and testbench

- Shares one 32-bit branch comparator between two requesters: port 0 is the branch unit and port 1 is the ALU SLT/SLTU path.
- Accepts compare requests over valid/ready, grants them round-robin, and registers the operands.
- Drives the comparator, decodes less/equal into a 1-bit result per func code, and returns it with the requester's tag over a held response channel.
- One request is in flight at a time.

---
 rtl/brc_pkg.sv | 25 ++
 rtl/brc_rr_grant2.sv | 19 +
 rtl/brc_arbiter.sv | 157 +++++++++++++++
 tb/tb_brc_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/brc_pkg.sv
// Shared types for the branch-comparator arbiter: compare function codes,
// arbiter FSM states and a helper that decides the comparator's signed mode.
package brc_pkg;

  typedef enum logic [2:0] {
    EQ  = 3'b000,
    NE  = 3'b001,
    LT  = 3'b100,
    GE  = 3'b101,
    LTU = 3'b110,
    GEU = 3'b111
  } cmp_func_e;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } arb_state_e;

  // Only LT/GE want the two's complement ordering from the comparator.
  function automatic logic is_signed_func(input logic [2:0] func);
    return (func == LT) || (func == GE);
  endfunction

endpackage

// File: rtl/brc_rr_grant2.sv
// Two-way round-robin grant: a lone requester always wins; on contention the
// requester that was not granted last (index != rr_ptr) wins.
module brc_rr_grant2 (
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/brc_arbiter.sv
// Shares one external 32-bit branch comparator between the branch unit (port 0)
// and the ALU SLT path (port 1). Define BRC_ARB_STATS_EN for saturating counters.
module brc_arbiter
  import brc_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [2:0]       i_req0_func,
  input  logic [2:0]       i_req1_func,
  input  logic [31:0]      i_req0_a,
  input  logic [31:0]      i_req0_b,
  input  logic [31:0]      i_req1_a,
  input  logic [31:0]      i_req1_b,
  input  logic [TAG_W-1:0] i_req0_tag,
  input  logic [TAG_W-1:0] i_req1_tag,
  output logic [31:0]      o_cmp_a,
  output logic [31:0]      o_cmp_b,
  output logic             o_cmp_br_un,
  input  logic             i_cmp_less,
  input  logic             i_cmp_equal,
  output logic [1:0]       o_rsp_valid,
  input  logic [1:0]       i_rsp_ready,
  output logic             o_rsp_result,
  output logic             o_rsp_illegal,
  output logic [TAG_W-1:0] o_rsp_tag
`ifdef BRC_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] o_stat_grant0,
  output logic [CNT_W-1:0] o_stat_grant1,
  output logic [CNT_W-1:0] o_stat_illegal,
  output logic [CNT_W-1:0] o_stat_stall
`endif
);

  arb_state_e       state_reg, state_next;
  logic             rr_ptr_reg;
  logic             id_reg;
  logic [31:0]      a_reg, b_reg;
  logic [2:0]       func_reg;
  logic [TAG_W-1:0] tag_reg;
  logic             result_reg, illegal_reg;
  logic             result_next, illegal_next;
  logic [1:0]       grant;
  logic             accept;

  brc_rr_grant2 u_grant (
    .valid  (i_req_valid),
    .rr_ptr (rr_ptr_reg),
    .grant  (grant)
  );

  assign accept      = (state_reg == IDLE) && (grant != 2'b00);
  assign o_req_ready = (state_reg == IDLE) ? grant : 2'b00;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant != 2'b00) state_next = EVAL;
      EVAL:    state_next = RESP;
      RESP:    if (i_rsp_ready[id_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    result_next  = 1'b0;
    illegal_next = 1'b0;
    case (func_reg)
      EQ:      result_next = i_cmp_equal;
      NE:      result_next = ~i_cmp_equal;
      LT, LTU: result_next = i_cmp_less;
      GE, GEU: result_next = ~i_cmp_less;
      default: illegal_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= 1'b0;
      id_reg      <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      func_reg    <= '0;
      tag_reg     <= '0;
      result_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rr_ptr_reg <= grant[1];
        id_reg     <= grant[1];
        a_reg      <= grant[1] ? i_req1_a    : i_req0_a;
        b_reg      <= grant[1] ? i_req1_b    : i_req0_b;
        func_reg   <= grant[1] ? i_req1_func : i_req0_func;
        tag_reg    <= grant[1] ? i_req1_tag  : i_req0_tag;
      end
      if (state_reg == EVAL) begin
        result_reg  <= result_next;
        illegal_reg <= illegal_next;
      end
    end
  end

  assign o_cmp_a       = a_reg;
  assign o_cmp_b       = b_reg;
  assign o_cmp_br_un   = (state_reg == EVAL) && is_signed_func(func_reg);
  assign o_rsp_result  = result_reg;
  assign o_rsp_illegal = illegal_reg;
  // tag_reg only changes on accept, so it stays stable across the whole response.
  assign o_rsp_tag     = tag_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp_valid
      assign o_rsp_valid[gi] = (state_reg == RESP) && (id_reg == 1'(gi));
    end
  endgenerate

`ifdef BRC_ARB_STATS_EN
  logic [CNT_W-1:0] grant0_cnt_reg, grant1_cnt_reg, illegal_cnt_reg, stall_cnt_reg;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant0_cnt_reg  <= '0;
      grant1_cnt_reg  <= '0;
      illegal_cnt_reg <= '0;
      stall_cnt_reg   <= '0;
    end else begin
      if (accept && grant[0] && grant0_cnt_reg != CNT_MAX)
        grant0_cnt_reg <= grant0_cnt_reg + CNT_ONE;
      if (accept && grant[1] && grant1_cnt_reg != CNT_MAX)
        grant1_cnt_reg <= grant1_cnt_reg + CNT_ONE;
      if (state_reg == EVAL && illegal_next && illegal_cnt_reg != CNT_MAX)
        illegal_cnt_reg <= illegal_cnt_reg + CNT_ONE;
      if ((i_req_valid & ~o_req_ready) != 2'b00 && stall_cnt_reg != CNT_MAX)
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
    end
  end

  assign o_stat_grant0  = grant0_cnt_reg;
  assign o_stat_grant1  = grant1_cnt_reg;
  assign o_stat_illegal = illegal_cnt_reg;
  assign o_stat_stall   = stall_cnt_reg;
`else
  // CNT_W only sizes the counters; keep it referenced when they are compiled out.
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_brc_arbiter.sv
// Self-checking bench for brc_arbiter: directed scenarios plus randomized
// transactions checked against a behavioural compare/round-robin model.
module tb_brc_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [2:0]  f0 = '0, f1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [3:0]  t0 = '0, t1 = '0;
  logic [31:0] cmp_a, cmp_b;
  logic        br_un, cmp_less, cmp_equal;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic        result, illegal;
  logic [3:0]  tag;
`ifdef BRC_ARB_STATS_EN
  logic [15:0] st_g0, st_g1, st_ill, st_stall;
`endif

  int total = 0;
  int bad = 0;
  int model_rr = 0;

  always #5 clk = ~clk;

  // External comparator model.
  assign cmp_less  = br_un ? ($signed(cmp_a) < $signed(cmp_b)) : (cmp_a < cmp_b);
  assign cmp_equal = (cmp_a == cmp_b);

  brc_arbiter #(.TAG_W(4), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req0_func(f0), .i_req1_func(f1),
    .i_req0_a(a0), .i_req0_b(b0), .i_req1_a(a1), .i_req1_b(b1),
    .i_req0_tag(t0), .i_req1_tag(t1),
    .o_cmp_a(cmp_a), .o_cmp_b(cmp_b), .o_cmp_br_un(br_un),
    .i_cmp_less(cmp_less), .i_cmp_equal(cmp_equal),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(result), .o_rsp_illegal(illegal), .o_rsp_tag(tag)
`ifdef BRC_ARB_STATS_EN
    , .o_stat_grant0(st_g0), .o_stat_grant1(st_g1),
    .o_stat_illegal(st_ill), .o_stat_stall(st_stall)
`endif
  );

  // Reference outcome {illegal, result} straight from the function-code table.
  function automatic logic [1:0] ref_cmp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return {1'b0, a == b};
      3'd1: return {1'b0, a != b};
      3'd4: return {1'b0, $signed(a) < $signed(b)};
      3'd5: return {1'b0, $signed(a) >= $signed(b)};
      3'd6: return {1'b0, a < b};
      3'd7: return {1'b0, a >= b};
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    total++; if ({result, illegal, tag} !== 6'd0) begin bad++; $display("FAIL reset_rsp_fields got=%b%b%h exp=000", result, illegal, tag); end
    total++; if ({cmp_a, cmp_b, br_un} !== 65'd0) begin bad++; $display("FAIL reset_cmp got a=%h b=%h un=%b exp 0", cmp_a, cmp_b, br_un); end
    rst_n = 1'b1;
    step();
    model_rr = 0;
  endtask

  task automatic test_single(input logic [2:0] func, input logic exp_un, input logic exp_res);
    f0 = func; a0 = 32'hFFFF_FFFF; b0 = 32'h0000_0001; t0 = 4'd3; req_valid = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready func=%b got=%b exp=01", func, req_ready); end
    step();
    req_valid = 2'b00; a0 = 32'h0; b0 = 32'h0; t0 = 4'd0;
    #1;
    total++; if (br_un !== exp_un) begin bad++; $display("FAIL single_br_un func=%b got=%b exp=%b", func, br_un, exp_un); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL single_early_rsp got=%b exp=00", rsp_valid); end
    step();
    total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL single_rsp_valid func=%b got=%b exp=01", func, rsp_valid); end
    total++; if ({result, illegal, tag} !== {exp_res, 1'b0, 4'd3}) begin bad++; $display("FAIL single_rsp func=%b got res=%b ill=%b tag=%h exp res=%b ill=0 tag=3", func, result, illegal, tag, exp_res); end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL single_rsp_drop got=%b exp=00", rsp_valid); end
    model_rr = 0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ready, cur;
    f0 = 3'd0; f1 = 3'd0; a0 = 32'd1; b0 = 32'd1; a1 = 32'd2; b1 = 32'd3;
    rsp_ready = 2'b11; req_valid = 2'b11;
    cur = 2'b00;
    #1;
    for (int k = 0; k < 12; k++) begin
      // model_rr is 0 here, so contention grants requester 1 first, then alternates.
      if (k % 3 == 0) cur = ((k / 3) % 2 == 0) ? 2'b10 : 2'b01;
      exp_ready = (k % 3 == 0) ? cur : 2'b00;
      total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rr_ready cycle=%0d got=%b exp=%b", k, req_ready, exp_ready); end
      if (k % 3 == 2) begin
        total++; if (rsp_valid !== cur) begin bad++; $display("FAIL rr_rsp cycle=%0d got=%b exp=%b", k, rsp_valid, cur); end
      end
      step();
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
    model_rr = 0;
    #1;
  endtask

  task automatic test_back_to_back_stall();
    f1 = 3'd0; a1 = 32'h1234; b1 = 32'h1234; t1 = 4'd9; req_valid = 2'b10;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_ready got=%b exp=10", req_ready); end
    step();
    f0 = 3'd0; a0 = 32'd5; b0 = 32'd5; t0 = 4'd2; req_valid = 2'b11;
    rsp_ready = 2'b01;  // wrong requester's ready must be ignored
    step();
    for (int i = 0; i < 5; i++) begin
      total++; if ({rsp_valid, result, tag} !== {2'b10, 1'b1, 4'd9}) begin bad++; $display("FAIL bp_hold cycle=%0d got valid=%b res=%b tag=%h exp valid=10 res=1 tag=9", i, rsp_valid, result, tag); end
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL bp_no_grant cycle=%0d got=%b exp=00", i, req_ready); end
      step();
    end
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
    total++; if ({rsp_valid, req_ready} !== 4'b0001) begin bad++; $display("FAIL bp_return_idle got valid=%b ready=%b exp 00/01", rsp_valid, req_ready); end
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    total++; if ({rsp_valid, result, tag} !== {2'b01, 1'b1, 4'd2}) begin bad++; $display("FAIL bp_second got valid=%b res=%b tag=%h exp 01/1/2", rsp_valid, result, tag); end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    model_rr = 0;
  endtask

  task automatic test_illegal();
    f0 = 3'b010; a0 = 32'd7; b0 = 32'd7; t0 = 4'd6; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    total++; if ({rsp_valid, result, illegal, tag} !== {2'b01, 1'b0, 1'b1, 4'd6}) begin bad++; $display("FAIL illegal got valid=%b res=%b ill=%b tag=%h exp 01/0/1/6", rsp_valid, result, illegal, tag); end
`ifdef BRC_ARB_STATS_EN
    total++; if (st_ill !== 16'd1) begin bad++; $display("FAIL stat_illegal got=%0d exp=1", st_ill); end
`endif
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    model_rr = 0;
  endtask

  task automatic test_reset_eval();
    f0 = 3'b100; a0 = 32'h0000_DEAD; b0 = 32'hBEEF_0000; t0 = 4'd5; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    #1;
    total++; if (br_un !== 1'b1 || cmp_a !== 32'h0000_DEAD) begin bad++; $display("FAIL rst_eval_pre got un=%b a=%h exp 1/dead", br_un, cmp_a); end
    rst_n = 1'b0;
    #1;
    total++; if ({cmp_a, cmp_b, br_un} !== 65'd0) begin bad++; $display("FAIL rst_eval_cmp got a=%h b=%h un=%b exp 0", cmp_a, cmp_b, br_un); end
    total++; if ({rsp_valid, req_ready, result, illegal, tag} !== 10'd0) begin bad++; $display("FAIL rst_eval_rsp got valid=%b ready=%b res=%b ill=%b tag=%h exp 0", rsp_valid, req_ready, result, illegal, tag); end
    step();
    rst_n = 1'b1;
    step();
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_eval_no_rsp got=%b exp=00", rsp_valid); end
    f1 = 3'd1; a1 = 32'd1; b1 = 32'd2; t1 = 4'd4; req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rst_eval_rr got=%b exp=10", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    total++; if ({rsp_valid, result, tag} !== {2'b10, 1'b1, 4'd4}) begin bad++; $display("FAIL rst_eval_after got valid=%b res=%b tag=%h exp 10/1/4", rsp_valid, result, tag); end
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
    model_rr = 1;
  endtask

  task automatic test_random();
    logic [1:0]  v, onehot, exp;
    int          g, stall;
    logic [2:0]  ef;
    logic [31:0] ea, eb;
    logic [3:0]  et;
    for (int n = 0; n < 40; n++) begin
      v  = 2'($urandom_range(1, 3));
      f0 = 3'($urandom_range(0, 7)); f1 = 3'($urandom_range(0, 7));
      a0 = pick_operand(); b0 = ($urandom_range(0, 3) == 0) ? a0 : pick_operand();
      a1 = pick_operand(); b1 = ($urandom_range(0, 3) == 0) ? a1 : pick_operand();
      t0 = 4'($urandom); t1 = 4'($urandom);
      g  = (v == 2'b11) ? ((model_rr == 0) ? 1 : 0) : ((v == 2'b01) ? 0 : 1);
      onehot = (g == 1) ? 2'b10 : 2'b01;
      ef = (g == 1) ? f1 : f0; ea = (g == 1) ? a1 : a0; eb = (g == 1) ? b1 : b0; et = (g == 1) ? t1 : t0;
      req_valid = v;
      #1;
      total++; if (req_ready !== onehot) begin bad++; $display("FAIL rand_grant n=%0d valid=%b got=%b exp=%b", n, v, req_ready, onehot); end
      step();
      model_rr = g;
      req_valid = 2'($urandom_range(0, 3));
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom; f0 = 3'($urandom); f1 = 3'($urandom);
      #1;
      total++; if ({req_ready, br_un} !== {2'b00, (ef == 3'd4 || ef == 3'd5)}) begin bad++; $display("FAIL rand_eval n=%0d got ready=%b un=%b func=%b", n, req_ready, br_un, ef); end
      total++; if ({cmp_a, cmp_b} !== {ea, eb}) begin bad++; $display("FAIL rand_operands n=%0d got %h/%h exp %h/%h", n, cmp_a, cmp_b, ea, eb); end
      step();
      exp = ref_cmp(ef, ea, eb);
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        total++; if ({rsp_valid, illegal, result, tag} !== {onehot, exp, et}) begin bad++; $display("FAIL rand_rsp n=%0d cyc=%0d func=%b a=%h b=%h got v=%b ill=%b res=%b tag=%h exp v=%b ill=%b res=%b tag=%h", n, s, ef, ea, eb, rsp_valid, illegal, result, tag, onehot, exp[1], exp[0], et); end
        rsp_ready = (s == stall) ? (onehot | 2'($urandom_range(0, 3))) : (~onehot & 2'($urandom_range(0, 3)));
        step();
      end
      req_valid = 2'b00; rsp_ready = 2'b00;
      #1;
      total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rand_handshake n=%0d got=%b exp=00", n, rsp_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single(3'b100, 1'b1, 1'b1);
    test_single(3'b110, 1'b0, 1'b0);
    test_round_robin();
    test_back_to_back_stall();
    test_illegal();
    test_reset_eval();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
